// File: rtl/nios_project_13_btn_pkg.sv
// Shared constants and types for the push-button Avalon-MM controller.
// Holds the register map, the edge bit positions and the debounce FSM states.
package nios_project_13_btn_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_CNT  = 2'd3;

  localparam int EDGE_PRESS   = 0;
  localparam int EDGE_RELEASE = 1;

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_CHK_PRESS,
    ST_PRESSED,
    ST_CHK_RELEASE
  } deb_state_e;

endpackage

// File: rtl/nios_project_13_btn_debounce.sv
// Two-flop synchroniser plus debounce FSM for one push-button.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive stable samples.
module nios_project_13_btn_debounce
  import nios_project_13_btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_port,
  output logic deb,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [1:0]  sync_q;
  logic        pressed_s;
  deb_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;

  // Synchroniser resets to the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= {2{ACTIVE_LOW}};
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
      sync_q  <= {sync_q[0], in_port};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pressed_s = sync_q[1] ^ ACTIVE_LOW;

  always_comb begin
    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    press_pulse   = 1'b0;
    release_pulse = 1'b0;
    case (state_q)
      ST_RELEASED: begin
        if (pressed_s) begin
          state_d = ST_CHK_PRESS;
          cnt_d   = '0;
        end
      end
      ST_CHK_PRESS: begin
        if (!pressed_s) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
          // The sample that left RELEASED counts as the first stable cycle.
          if (cnt_d == CNT_LAST) begin
            state_d     = ST_PRESSED;
            cnt_d       = '0;
            press_pulse = 1'b1;
          end
        end
      end
      ST_PRESSED: begin
        if (!pressed_s) begin
          state_d = ST_CHK_RELEASE;
          cnt_d   = '0;
        end
      end
      ST_CHK_RELEASE: begin
        if (pressed_s) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == CNT_LAST) begin
            state_d       = ST_RELEASED;
            cnt_d         = '0;
            release_pulse = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign deb = (state_q == ST_PRESSED) || (state_q == ST_CHK_RELEASE);

endmodule

// File: rtl/nios_project_13_btn_ctrl.sv
// Avalon-MM push-button controller: debounced level, sticky edge capture,
// saturating press counter and a maskable level interrupt.
module nios_project_13_btn_ctrl
  import nios_project_13_btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int CNT_W           = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        in_port,
  output logic        irq
);

  logic             deb, press_pulse, release_pulse;
  logic             wr_en;
  logic [1:0]       mask_q, edge_q, edge_set, edge_clr;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  nios_project_13_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_deb (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_port      (in_port),
    .deb          (deb),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  assign wr_en        = chipselect && !write_n;
  assign edge_clr     = (wr_en && address == ADDR_EDGE) ? writedata[1:0] : 2'b00;
  assign unused_wdata = &{1'b0, writedata[31:2]};

  always_comb begin
    edge_set               = '0;
    edge_set[EDGE_PRESS]   = press_pulse;
    edge_set[EDGE_RELEASE] = release_pulse;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux[0]         = deb;
      ADDR_MASK: rd_mux[1:0]       = mask_q;
      ADDR_EDGE: rd_mux[1:0]       = edge_q;
      ADDR_CNT:  rd_mux[CNT_W-1:0] = cnt_q;
      default:   rd_mux            = '0;
    endcase
  end

  // NOTE: this is a handful of control flops, not a memory array, so each one takes the async reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q   <= '0;
      edge_q   <= '0;
      cnt_q    <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      if (wr_en && address == ADDR_MASK) mask_q <= writedata[1:0];
      // OR-ing the set after the clear makes a simultaneous pulse win.
      edge_q <= (edge_q & ~edge_clr) | edge_set;
      if (wr_en && address == ADDR_CNT) begin
        cnt_q <= {{(CNT_W-1){1'b0}}, press_pulse};
      end else if (press_pulse && !(&cnt_q)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      irq      <= |(edge_q & mask_q);
      readdata <= rd_mux;
    end
  end

endmodule
